i2s_stereo_framer: RTL and testbench

- Sits directly downstream of two single-channel I2S receivers: one for the left slot and one for the right slot.
- Pairs each left sample with the following right sample into one stereo frame.
- Buffers frames in a small first-word-fall-through FIFO and presents them to the mixer core over a valid/ready handshake.
- Flags channel-ordering errors and FIFO overflow.

---
 rtl/i2s_stereo_framer.sv | 212 +++++++++++++++++++++
 tb/tb_i2s_stereo_framer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_stereo_framer.sv
// i2s_stereo_framer
// Pairs a left-slot sample with the right-slot sample that follows it to form
// one stereo frame. Frames are buffered in a small first-word-fall-through
// FIFO and offered to the consumer over a valid/ready handshake. The block
// flags channel-ordering errors (one-cycle pulse) and dropped frames (sticky).
// All outputs come straight from registers: the FIFO head is precomputed from
// next-state values, so the visible head never passes through combinational
// logic after the clock edge.

module i2s_stereo_framer #(
  parameter int BITS_PRECISION = 24,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          sck,
  input  logic                          rst,
  input  logic [BITS_PRECISION-1:0]     left_data,
  input  logic                          left_en,
  input  logic [BITS_PRECISION-1:0]     right_data,
  input  logic                          right_en,
  output logic [BITS_PRECISION-1:0]     frame_left,
  output logic [BITS_PRECISION-1:0]     frame_right,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic                          sync_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    WAIT_LEFT  = 1'b0,
    WAIT_RIGHT = 1'b1
  } state_t;

  // Pairing state
  state_t                    state_r;
  state_t                    state_s;
  logic [BITS_PRECISION-1:0] hold_r;
  logic [BITS_PRECISION-1:0] hold_s;
  logic                      sync_err_s;
  logic                      push_req_s;

  // Enable edge detection
  logic                      left_en_d_r;
  logic                      right_en_d_r;
  logic                      lstb_s;
  logic                      rstb_s;

  // FIFO storage and bookkeeping
  logic [BITS_PRECISION-1:0] mem_left_r  [FIFO_DEPTH];
  logic [BITS_PRECISION-1:0] mem_right_r [FIFO_DEPTH];
  logic [PTR_W-1:0]          rd_ptr_r;
  logic [PTR_W-1:0]          wr_ptr_r;
  logic [PTR_W-1:0]          rd_ptr_s;
  logic [PTR_W-1:0]          wr_ptr_s;
  logic [CNT_W-1:0]          count_s;
  logic                      pop_s;
  logic                      full_s;
  logic                      push_ok_s;
  logic                      drop_s;
  logic [BITS_PRECISION-1:0] head_left_s;
  logic [BITS_PRECISION-1:0] head_right_s;

  // Rising-edge strobes: a held or stretched enable counts only once
  always_comb begin
    lstb_s = left_en & ~left_en_d_r;
    rstb_s = right_en & ~right_en_d_r;
  end

  // Delayed enables; loaded high in reset so an enable already high at release is ignored
  always_ff @(posedge sck) begin
    if (!rst) begin
      left_en_d_r  <= 1'b1;
      right_en_d_r <= 1'b1;
    end else begin
      left_en_d_r  <= left_en;
      right_en_d_r <= right_en;
    end
  end

  // Pairing FSM next-state: latch left, pair with next right, flag misordering
  always_comb begin
    state_s    = state_r;
    hold_s     = hold_r;
    sync_err_s = 1'b0;
    push_req_s = 1'b0;
    case (state_r)
      WAIT_LEFT: begin
        if (lstb_s && rstb_s) begin
          sync_err_s = 1'b1;
        end else if (lstb_s) begin
          hold_s  = left_data;
          state_s = WAIT_RIGHT;
        end else if (rstb_s) begin
          sync_err_s = 1'b1;
        end else begin
          state_s = WAIT_LEFT;
        end
      end
      WAIT_RIGHT: begin
        if (lstb_s && rstb_s) begin
          sync_err_s = 1'b1;
          state_s    = WAIT_LEFT;
        end else if (rstb_s) begin
          push_req_s = 1'b1;
          state_s    = WAIT_LEFT;
        end else if (lstb_s) begin
          // A second left before any right replaces the held sample
          hold_s     = left_data;
          sync_err_s = 1'b1;
        end else begin
          state_s = WAIT_RIGHT;
        end
      end
      default: begin
        state_s = WAIT_LEFT;
        hold_s  = {BITS_PRECISION{1'b0}};
      end
    endcase
  end

  // Pairing FSM state, held left sample and registered error pulse
  always_ff @(posedge sck) begin
    if (!rst) begin
      state_r  <= WAIT_LEFT;
      hold_r   <= {BITS_PRECISION{1'b0}};
      sync_err <= 1'b0;
    end else begin
      state_r  <= state_s;
      hold_r   <= hold_s;
      sync_err <= sync_err_s;
    end
  end

  // FIFO control: push/pop qualification, pointer and count next values
  always_comb begin
    pop_s     = frame_valid & frame_ready;
    full_s    = (fill_level == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
    push_ok_s = push_req_s & (~full_s | pop_s);
    drop_s    = push_req_s & full_s & ~pop_s;

    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_s = rd_ptr_r;
    end

    if (push_ok_s) begin
      wr_ptr_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_s = wr_ptr_r;
    end

    case ({push_ok_s, pop_s})
      2'b10:   count_s = fill_level + CNT_W'(1);
      2'b01:   count_s = fill_level - CNT_W'(1);
      default: count_s = fill_level;
    endcase
  end

  // Next FIFO head: zero when empty, the incoming frame if it lands at the head slot
  always_comb begin
    if (count_s == {CNT_W{1'b0}}) begin
      head_left_s  = {BITS_PRECISION{1'b0}};
      head_right_s = {BITS_PRECISION{1'b0}};
    end else if (push_ok_s && (wr_ptr_r == rd_ptr_s)) begin
      head_left_s  = hold_r;
      head_right_s = right_data;
    end else begin
      head_left_s  = mem_left_r[rd_ptr_s];
      head_right_s = mem_right_r[rd_ptr_s];
    end
  end

  // FIFO storage write; contents cleared in reset so stale frames never resurface
  always_ff @(posedge sck) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_left_r[i]  <= {BITS_PRECISION{1'b0}};
        mem_right_r[i] <= {BITS_PRECISION{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_left_r[wr_ptr_r]  <= hold_r;
      mem_right_r[wr_ptr_r] <= right_data;
    end
  end

  // FIFO pointers, fill level, registered head outputs and sticky overflow
  always_ff @(posedge sck) begin
    if (!rst) begin
      rd_ptr_r    <= {PTR_W{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      fill_level  <= {CNT_W{1'b0}};
      frame_valid <= 1'b0;
      frame_left  <= {BITS_PRECISION{1'b0}};
      frame_right <= {BITS_PRECISION{1'b0}};
      overflow    <= 1'b0;
    end else begin
      rd_ptr_r    <= rd_ptr_s;
      wr_ptr_r    <= wr_ptr_s;
      fill_level  <= count_s;
      frame_valid <= (count_s != {CNT_W{1'b0}});
      frame_left  <= head_left_s;
      frame_right <= head_right_s;
      overflow    <= overflow | drop_s;
    end
  end

endmodule

// File: tb/tb_i2s_stereo_framer.sv
// Directed testbench for i2s_stereo_framer: a table of single-cycle vectors
// for pairing and ordering rules, then hand-written multi-cycle sequences for
// overflow, full push/pop, stretched enables and mid-stream reset.

module tb_i2s_stereo_framer;

  localparam int W = 24;
  localparam int D = 4;

  logic         sck;
  logic         rst;
  logic [W-1:0] left_data;
  logic         left_en;
  logic [W-1:0] right_data;
  logic         right_en;
  logic [W-1:0] frame_left;
  logic [W-1:0] frame_right;
  logic         frame_valid;
  logic         frame_ready;
  logic [2:0]   fill_level;
  logic         overflow;
  logic         sync_err;

  int tests_run;
  int tests_failed;

  i2s_stereo_framer #(.BITS_PRECISION(W), .FIFO_DEPTH(D)) dut (
    .sck         (sck),
    .rst         (rst),
    .left_data   (left_data),
    .left_en     (left_en),
    .right_data  (right_data),
    .right_en    (right_en),
    .frame_left  (frame_left),
    .frame_right (frame_right),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .fill_level  (fill_level),
    .overflow    (overflow),
    .sync_err    (sync_err)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  typedef struct {
    logic         rst;
    logic         le;
    logic [W-1:0] ld;
    logic         re;
    logic [W-1:0] rd;
    logic         rdy;
    logic         fv;
    logic [W-1:0] fl;
    logic [W-1:0] fr;
    logic [2:0]   lvl;
    logic         ovf;
    logic         serr;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic le, input logic [W-1:0] ld,
                              input logic re, input logic [W-1:0] rd, input logic rdy,
                              input logic fv, input logic [W-1:0] fl, input logic [W-1:0] fr,
                              input logic [2:0] lvl, input logic ovf, input logic serr);
    vec_t v;
    v.rst = r; v.le = le; v.ld = ld; v.re = re; v.rd = rd; v.rdy = rdy;
    v.fv = fv; v.fl = fl; v.fr = fr; v.lvl = lvl; v.ovf = ovf; v.serr = serr;
    return v;
  endfunction

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic fv, input logic [W-1:0] fl,
                           input logic [W-1:0] fr, input logic [2:0] lvl,
                           input logic ovf, input logic serr);
    chk({tag, " frame_valid"}, 64'(frame_valid), 64'(fv));
    chk({tag, " frame_left"},  64'(frame_left),  64'(fl));
    chk({tag, " frame_right"}, 64'(frame_right), 64'(fr));
    chk({tag, " fill_level"},  64'(fill_level),  64'(lvl));
    chk({tag, " overflow"},    64'(overflow),    64'(ovf));
    chk({tag, " sync_err"},    64'(sync_err),    64'(serr));
  endtask

  task automatic pulse_left(input logic [W-1:0] v);
    left_data = v; left_en = 1'b1; tick();
    left_en = 1'b0; tick();
  endtask

  task automatic pulse_right(input logic [W-1:0] v);
    right_data = v; right_en = 1'b1; tick();
    right_en = 1'b0; tick();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0; left_en = 1'b0; right_en = 1'b0; frame_ready = 1'b0;
    left_data = '0; right_data = '0;

    //                rst le ld         re rd         rdy  fv fl         fr         lvl ovf serr
    vecs[0]  = mk(1'b0,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[1]  = mk(1'b0,1'b1,24'h55,    1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[2]  = mk(1'b1,1'b1,24'h55,    1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[3]  = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[4]  = mk(1'b1,1'b0,24'h0,     1'b1,24'h5,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b1);
    vecs[5]  = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[6]  = mk(1'b1,1'b1,24'h123456,1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[7]  = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[8]  = mk(1'b1,1'b0,24'h0,     1'b1,24'hABCDEF,1'b0, 1'b1,24'h123456,24'hABCDEF,3'd1,1'b0,1'b0);
    vecs[9]  = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b1,24'h123456,24'hABCDEF,3'd1,1'b0,1'b0);
    vecs[10] = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b1, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[11] = mk(1'b1,1'b0,24'h0,     1'b1,24'h000001,1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b1);
    vecs[12] = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[13] = mk(1'b1,1'b1,24'h11,    1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[14] = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[15] = mk(1'b1,1'b1,24'h22,    1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b1);
    vecs[16] = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[17] = mk(1'b1,1'b0,24'h0,     1'b1,24'h33,    1'b0, 1'b1,24'h22,    24'h33,    3'd1,1'b0,1'b0);
    vecs[18] = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b1,24'h22,    24'h33,    3'd1,1'b0,1'b0);
    vecs[19] = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b1, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[20] = mk(1'b1,1'b1,24'h77,    1'b1,24'h88,    1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b1);
    vecs[21] = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b1, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[22] = mk(1'b1,1'b1,24'h44,    1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[23] = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[24] = mk(1'b1,1'b1,24'h45,    1'b1,24'h46,    1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b1);
    vecs[25] = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);
    vecs[26] = mk(1'b1,1'b0,24'h0,     1'b1,24'h66,    1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b1);
    vecs[27] = mk(1'b1,1'b0,24'h0,     1'b0,24'h0,     1'b0, 1'b0,24'h0,     24'h0,     3'd0,1'b0,1'b0);

    // Table: reset, basic pairing, ordering errors
    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; left_en = vecs[i].le; left_data = vecs[i].ld;
      right_en = vecs[i].re; right_data = vecs[i].rd; frame_ready = vecs[i].rdy;
      tick();
      check_out($sformatf("row%0d", i), vecs[i].fv, vecs[i].fl, vecs[i].fr,
                vecs[i].lvl, vecs[i].ovf, vecs[i].serr);
    end
    left_en = 1'b0; right_en = 1'b0; frame_ready = 1'b0;

    // Overflow: five frames into a depth-4 FIFO with no consumer
    for (int i = 1; i <= 5; i++) begin
      pulse_left(W'(i));
      pulse_right(W'(100 + i));
    end
    check_out("ovf_full", 1'b1, 24'd1, 24'd101, 3'd4, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_pop%0d left", k),  64'(frame_left),  64'(k));
      chk($sformatf("ovf_pop%0d right", k), 64'(frame_right), 64'(100 + k));
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
    end
    check_out("ovf_drained", 1'b0, 24'd0, 24'd0, 3'd0, 1'b1, 1'b0);

    // Reset clears the sticky overflow
    rst = 1'b0; tick(); rst = 1'b1; tick();
    check_out("ovf_cleared", 1'b0, 24'd0, 24'd0, 3'd0, 1'b0, 1'b0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 1; i <= 4; i++) begin
      pulse_left(W'(i));
      pulse_right(W'(100 + i));
    end
    check_out("pp_full", 1'b1, 24'd1, 24'd101, 3'd4, 1'b0, 1'b0);
    pulse_left(24'd5);
    right_data = 24'd105; right_en = 1'b1; frame_ready = 1'b1;
    tick();
    right_en = 1'b0; frame_ready = 1'b0;
    check_out("pp_same_cycle", 1'b1, 24'd2, 24'd102, 3'd4, 1'b0, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("pp_pop%0d left", k),  64'(frame_left),  64'(k));
      chk($sformatf("pp_pop%0d right", k), 64'(frame_right), 64'(100 + k));
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
    end
    check_out("pp_drained", 1'b0, 24'd0, 24'd0, 3'd0, 1'b0, 1'b0);

    // Stretched enables count once; a later right re-pulse is an ordering error
    left_data = 24'hA1; left_en = 1'b1;
    tick(); tick(); tick();
    left_en = 1'b0; tick();
    check_out("str_left", 1'b0, 24'd0, 24'd0, 3'd0, 1'b0, 1'b0);
    right_data = 24'hB1; right_en = 1'b1;
    tick();
    check_out("str_push", 1'b1, 24'hA1, 24'hB1, 3'd1, 1'b0, 1'b0);
    tick();
    check_out("str_hold2", 1'b1, 24'hA1, 24'hB1, 3'd1, 1'b0, 1'b0);
    tick();
    check_out("str_hold3", 1'b1, 24'hA1, 24'hB1, 3'd1, 1'b0, 1'b0);
    right_en = 1'b0; tick(); tick();
    check_out("str_gap", 1'b1, 24'hA1, 24'hB1, 3'd1, 1'b0, 1'b0);
    right_data = 24'hC1; right_en = 1'b1; tick();
    check_out("str_repulse", 1'b1, 24'hA1, 24'hB1, 3'd1, 1'b0, 1'b1);
    right_en = 1'b0; tick();
    check_out("str_after", 1'b1, 24'hA1, 24'hB1, 3'd1, 1'b0, 1'b0);

    // Reset mid-stream with two frames buffered and a held left sample
    pulse_left(24'hD1);
    pulse_right(24'hE1);
    chk("rst_pre fill_level", 64'(fill_level), 64'd2);
    pulse_left(24'hF1);
    rst = 1'b0; tick();
    check_out("rst_mid", 1'b0, 24'd0, 24'd0, 3'd0, 1'b0, 1'b0);
    rst = 1'b1; tick();
    right_data = 24'h77; right_en = 1'b1; tick();
    check_out("rst_rstb", 1'b0, 24'd0, 24'd0, 3'd0, 1'b0, 1'b1);
    right_en = 1'b0; tick();
    check_out("rst_after", 1'b0, 24'd0, 24'd0, 3'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
